// File: rtl/power_est_pkg.sv
// Shared constants for the power-estimation path: FSM encoding and default
// counter/window widths that the downstream accumulator also uses.
package power_est_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DUMP  = 2'd2;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/toggle_cell.sv
// One probe bit: previous-sample flop, XOR edge detect and a saturating
// toggle counter.
module toggle_cell
  import power_est_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic prev;
  logic toggle;

  assign toggle = bit_in ^ prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      count <= '0;
    end else if (clr) begin
      prev  <= bit_in;
      count <= '0;
    end else if (en) begin
      prev <= bit_in;
      if (toggle && (count != '1))
        count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/toggle_activity_counter.sv
// Counts per-bit probe toggles over a programmed window, then streams one
// count per bit over a valid/ready port.
module toggle_activity_counter
  import power_est_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             done
);

  localparam logic [WIN_W-1:0] WIN_ONE  = 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIN_W-1:0] rem;
  logic             clr;
  logic             en;
  logic [CNT_W-1:0] cnt [WIDTH];

  assign clr  = (state == ST_IDLE) && start;
  assign en   = (state == ST_COUNT);
  assign busy = (state != ST_IDLE);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    toggle_cell #(.CNT_W(CNT_W)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .en     (en),
      .bit_in (probe[i]),
      .count  (cnt[i])
    );
  end

  // Counters are frozen during DUMP, so selecting straight from them gives a
  // registered value without an extra pipeline stage that would lag the last compare.
  always_comb begin
    out_count = '0;
    if (out_valid)
      out_count = cnt[out_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rem       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem     <= win_len;
            out_idx <= '0;
            if (win_len == '0) begin
              state     <= ST_DUMP;
              out_valid <= 1'b1;
            end else begin
              state <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          rem <= rem - WIN_ONE;
          if (rem == WIN_ONE) begin
            state     <= ST_DUMP;
            out_valid <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (out_valid && out_ready) begin
            if (out_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_idx   <= '0;
              done      <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              out_idx <= out_idx + IDX_ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Scoreboard bench: two instances (16-bit and 4-bit counters) share stimulus;
// expected beats are queued at start and checked by an independent monitor.
module tb_toggle_activity_counter;

  typedef struct {
    int idx;
    int cnt;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] win_len;
  logic [3:0]  probe;
  logic        out_ready;

  logic        busy_a, out_valid_a, done_a;
  logic [1:0]  out_idx_a;
  logic [15:0] out_count_a;
  logic        busy_b, out_valid_b, done_b;
  logic [1:0]  out_idx_b;
  logic [3:0]  out_count_b;

  logic [3:0]  tog_mask;
  int          stall_idx;
  int          stall_left;
  int          errors = 0;
  int          checks = 0;
  beat_t       sb[$];

  bit          pv_valid = 0, pv_ready = 0, pv_hs = 0, pv_last = 0;
  logic [1:0]  pv_idx;
  logic [15:0] pv_cnt;

  toggle_activity_counter #(.WIDTH(4), .CNT_W(16), .WIN_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .probe(probe),
    .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_idx(out_idx_a), .out_count(out_count_a), .done(done_a)
  );

  toggle_activity_counter #(.WIDTH(4), .CNT_W(4), .WIN_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .probe(probe),
    .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_idx(out_idx_b), .out_count(out_count_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // probe bits in tog_mask flip once per clock, just after each posedge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      probe = probe ^ tog_mask;
    end
  end

  // out_ready low for stall_left cycles once beat stall_idx is presented
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && out_valid_a && int'(out_idx_a) == stall_idx) begin
        out_ready  = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // monitor
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv_valid = 0; pv_ready = 0; pv_hs = 0; pv_last = 0;
      end else begin
        chk("done_pulse", {done_a, done_b}, pv_last ? 32'd3 : 32'd0);
        if (pv_last) chk("valid_after_last", out_valid_a, 0);
        if (pv_hs && !pv_last) chk("no_bubble", out_valid_a, 1);
        if (pv_valid && !pv_ready) begin
          chk("stall_valid", out_valid_a, 1);
          chk("stall_idx", out_idx_a, pv_idx);
          chk("stall_count", out_count_a, pv_cnt);
        end
        pv_hs = 0;
        pv_last = 0;
        if (out_valid_a && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: idx %0d with nothing queued", out_idx_a);
          end else begin
            e = sb.pop_front();
            chk("beat_idx_a", out_idx_a, e.idx);
            chk("beat_count_a", out_count_a, e.cnt);
            chk("beat_idx_b", out_idx_b, e.idx);
            chk("beat_count_b", out_count_b, (e.cnt > 15) ? 15 : e.cnt);
          end
          pv_hs = 1;
          pv_last = (out_idx_a == 2'd3);
        end
        pv_valid = out_valid_a;
        pv_ready = out_ready;
        pv_idx   = out_idx_a;
        pv_cnt   = out_count_a;
      end
    end
  end

  task automatic launch(input int wl, input logic [3:0] mask, input bit push);
    @(posedge clk);
    #1;
    tog_mask = mask;
    win_len  = 16'(wl);
    start    = 1'b1;
    if (push)
      for (int k = 0; k < 4; k++) sb.push_back('{k, mask[k] ? wl : 0});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within 300 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; win_len = '0; probe = '0; out_ready = 1'b1;
    tog_mask = '0; stall_idx = 0; stall_left = 0;
    #12;
    chk("rst_busy", {busy_a, busy_b}, 0);
    chk("rst_valid", {out_valid_a, out_valid_b}, 0);
    chk("rst_done", {done_a, done_b}, 0);
    chk("rst_idx", {out_idx_a, out_idx_b}, 0);
    chk("rst_count_a", out_count_a, 0);
    chk("rst_count_b", out_count_b, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic window, bit 0 toggling
    launch(10, 4'b0001, 1);
    chk("count_busy", busy_a, 1);
    wait_done("t1_done");

    // saturation in the 4-bit instance
    launch(20, 4'b0010, 1);
    wait_done("t2_done");

    // zero-length window goes straight to DUMP
    launch(0, 4'b0000, 1);
    chk("wl0_busy", busy_a, 1);
    chk("wl0_valid_first_cycle", out_valid_a, 1);
    wait_done("t3_done");
    chk("wl0_busy_at_done", busy_a, 0);

    // backpressure on beat 2
    stall_idx = 2;
    stall_left = 3;
    launch(7, 4'b1100, 1);
    wait_done("t4_done");
    chk("stall_consumed", stall_left, 0);

    // asynchronous reset 5 cycles into COUNT
    launch(12, 4'b1111, 0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", {busy_a, busy_b}, 0);
    chk("abort_valid", {out_valid_a, out_valid_b}, 0);
    chk("abort_count", out_count_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    launch(4, 4'b0110, 1);
    wait_done("t5_done");

    // extra start pulses during COUNT and DUMP are ignored
    launch(6, 4'b1001, 1);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    begin
      int n = 0;
      while (!(out_valid_a && out_idx_a == 2'd1) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t6_reached_beat1", out_idx_a, 1);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t6_done");
    @(negedge clk);
    chk("t6_no_restart", busy_a, 0);

    // start in the cycle done is high is accepted
    launch(3, 4'b0001, 1);
    wait_done("t7a_done");
    tog_mask = 4'b0100;
    win_len  = 16'd5;
    start    = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back('{k, (k == 2) ? 5 : 0});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t7_busy_after_done_start", busy_a, 1);
    wait_done("t7b_done");

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
